// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU operand-issue path: ALU control codes,
// MIPS opcode/funct encodings and the buffered entry layout.
package alu_pkg;

   localparam int ALU_DATA_W = 32;
   localparam int ALU_CTRL_W = 3;

   localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b111;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef struct packed {
      logic [ALU_CTRL_W-1:0] code;
      logic [ALU_DATA_W-1:0] srca;
      logic [ALU_DATA_W-1:0] srcb;
      logic                  illegal;
   } entry_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct into the ALU control code, plus operand
// selection (register rt or sign-extended 16-bit immediate for I-type).
module alu_op_decode
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int CTRL_W = ALU_CTRL_W
) (
   input  logic [DATA_W-1:0] instr,
   input  logic [DATA_W-1:0] rs_val,
   input  logic [DATA_W-1:0] rt_val,
   output logic [CTRL_W-1:0] code,
   output logic [DATA_W-1:0] srca,
   output logic [DATA_W-1:0] srcb,
   output logic              illegal
);

   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic [DATA_W-1:0] imm_sext;
   logic              unused_fields;

   assign opcode        = instr[31:26];
   assign funct         = instr[5:0];
   assign imm_sext      = {{(DATA_W-16){instr[15]}}, instr[15:0]};
   assign unused_fields = ^instr[25:16];
   assign srca          = rs_val;

   always_comb begin
      // Unsupported encodings still issue as ADD on rt so the datapath stays defined.
      code    = ALU_ADD;
      srcb    = rt_val;
      illegal = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            illegal = 1'b0;
            case (funct)
               FN_ADD:  code = ALU_ADD;
               FN_SUB:  code = ALU_SUB;
               FN_AND:  code = ALU_AND;
               FN_OR:   code = ALU_OR;
               FN_SLT:  code = ALU_SLT;
               default: illegal = 1'b1;
            endcase
         end
         OP_LW, OP_SW, OP_ADDI: begin
            illegal = 1'b0;
            srcb    = imm_sext;
         end
         OP_BEQ: begin
            illegal = 1'b0;
            code    = ALU_SUB;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_op_issue.sv
// Issue stage between register read and execute: decodes at accept time and
// holds up to two finished entries in a skid FIFO in front of the ALU.
module alu_op_issue
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int CTRL_W = ALU_CTRL_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] instr,
   input  logic [DATA_W-1:0] rs_val,
   input  logic [DATA_W-1:0] rt_val,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] inputULA,
   output logic [DATA_W-1:0] srca,
   output logic [DATA_W-1:0] srcb,
   output logic              illegal
);

   // Handshake: a transfer happens on a rising edge where valid && ready are both
   // high; in_ready comes only from registered state, never from out_ready.

   entry_t      mem_q [2];
   entry_t      mem_d [2];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;
   logic        en_q, en_d;

   entry_t      dec_entry;
   entry_t      head;
   logic        push;
   logic        pop;

   alu_op_decode #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
   ) u_decode (
      .instr   (instr),
      .rs_val  (rs_val),
      .rt_val  (rt_val),
      .code    (dec_entry.code),
      .srca    (dec_entry.srca),
      .srcb    (dec_entry.srcb),
      .illegal (dec_entry.illegal)
   );

   assign out_valid = (count_q != 2'd0);
   // en_q holds in_ready low until the first edge after reset release.
   assign in_ready  = en_q && (count_q != 2'd2);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign head      = mem_q[rd_ptr_q];

   assign inputULA = out_valid ? head.code    : '0;
   assign srca     = out_valid ? head.srca    : '0;
   assign srcb     = out_valid ? head.srcb    : '0;
   assign illegal  = out_valid ? head.illegal : 1'b0;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      en_d     = 1'b1;
      if (flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = dec_entry;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         en_q     <= 1'b0;
      end else begin
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         en_q     <= en_d;
      end
   end

endmodule

// File: tb/tb_alu_op_issue.sv
// Randomized and directed bench for alu_op_issue with a queue-based reference
// model of the two-entry buffer and a decode table written from the ISA rules.
module tb_alu_op_issue;

   localparam int W  = 32;
   localparam int EW = 3 + W + W + 1;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  instr;
   logic [W-1:0]  rs_val;
   logic [W-1:0]  rt_val;
   logic          out_valid;
   logic          out_ready;
   logic [2:0]    inputULA;
   logic [W-1:0]  srca;
   logic [W-1:0]  srcb;
   logic          illegal;

   logic [EW-1:0] exp_q[$];
   logic          ready_en;
   int            n_vec;
   int            n_err;

   alu_op_issue dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .inputULA  (inputULA),
      .srca      (srca),
      .srcb      (srcb),
      .illegal   (illegal)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference decode: {code, srca, srcb, illegal}
   function automatic logic [EW-1:0] ref_decode(input logic [W-1:0] ins,
                                                input logic [W-1:0] rs,
                                                input logic [W-1:0] rt);
      int unsigned op;
      int unsigned fn;
      logic [2:0]  code;
      logic [W-1:0] b;
      logic        ill;
      op   = ins[31:26];
      fn   = ins[5:0];
      code = 3'd2;
      b    = rt;
      ill  = 1'b1;
      if (op == 0) begin
         if (fn == 32) begin code = 3'd2; ill = 1'b0; end
         if (fn == 34) begin code = 3'd6; ill = 1'b0; end
         if (fn == 36) begin code = 3'd0; ill = 1'b0; end
         if (fn == 37) begin code = 3'd1; ill = 1'b0; end
         if (fn == 42) begin code = 3'd7; ill = 1'b0; end
      end else if (op == 35 || op == 43 || op == 8) begin
         ill = 1'b0;
         b   = W'($signed(ins[15:0]));
      end else if (op == 4) begin
         ill  = 1'b0;
         code = 3'd6;
      end
      return {code, rs, b, ill};
   endfunction

   task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // reference model of the buffer, updated on the same edges as the DUT
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         ready_en = 1'b0;
      end else begin
         logic mv;
         logic mr;
         mv = (exp_q.size() != 0);
         mr = ready_en && (exp_q.size() < 2);
         if (flush) begin
            exp_q.delete();
         end else begin
            if (mv && out_ready) void'(exp_q.pop_front());
            if (in_valid && mr) exp_q.push_back(ref_decode(instr, rs_val, rt_val));
         end
         ready_en = 1'b1;
      end
   end

   // monitor: compare DUT outputs against the head of the expected queue
   always @(negedge clk) begin
      logic          ev;
      logic          er;
      logic [EW-1:0] eh;
      ev = (exp_q.size() != 0);
      er = rst_n && ready_en && (exp_q.size() < 2);
      eh = ev ? exp_q[0] : '0;
      chk("out_valid", EW'(out_valid), EW'(ev));
      chk("in_ready", EW'(in_ready), EW'(er));
      chk("head", {inputULA, srca, srcb, illegal}, eh);
   end

   // driver tasks
   task automatic idle(input int n);
      in_valid = 1'b0;
      flush    = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [W-1:0] ins, input logic [W-1:0] rs, input logic [W-1:0] rt);
      logic acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      instr    = ins;
      rs_val   = rs;
      rt_val   = rt;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: in_ready stayed 0 for instr %h", ins);
      end
      in_valid = 1'b0;
   endtask

   function automatic logic [W-1:0] rand_instr();
      logic [W-1:0] w;
      logic [5:0]   ops [5];
      logic [5:0]   fns [5];
      int           k;
      ops = '{6'd0, 6'd35, 6'd43, 6'd8, 6'd4};
      fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
      w = $urandom;
      k = $urandom_range(0, 7);
      if (k < 5) begin
         w[31:26] = 6'd0;
         w[5:0]   = fns[k];
      end else if (k == 5) begin
         w[31:26] = ops[$urandom_range(1, 3)];
      end else if (k == 6) begin
         w[31:26] = ops[4];
      end
      return w;
   endfunction

   initial begin
      n_vec     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      instr     = '0;
      rs_val    = '0;
      rt_val    = '0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single R-type add, then addi with negative immediate
      out_ready = 1'b1;
      send(32'h00221820, 32'd5, 32'd7);
      idle(2);
      send(32'h2021FFFC, 32'd10, $urandom);
      idle(2);

      // backpressure: two accepted, third held until the head drains
      out_ready = 1'b0;
      send(32'h00221822, $urandom, $urandom);
      send(32'h00221824, $urandom, $urandom);
      in_valid = 1'b1;
      instr    = 32'h0022182A;
      rs_val   = $urandom;
      rt_val   = $urandom;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(32'h0022182A, rs_val, rt_val);
      idle(4);

      // illegal opcode and beq
      send(32'hFC000000, $urandom, $urandom);
      send(32'h10220003, 32'd3, 32'd9);
      idle(3);

      // flush with a full buffer and a concurrent offer
      out_ready = 1'b0;
      send(rand_instr(), $urandom, $urandom);
      send(rand_instr(), $urandom, $urandom);
      in_valid = 1'b1;
      instr    = rand_instr();
      flush    = 1'b1;
      @(posedge clk);
      #1;
      idle(3);

      // randomized traffic with occasional flush
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         instr     = rand_instr();
         rs_val    = $urandom;
         rt_val    = $urandom;
         @(posedge clk);
         #1;
      end
      idle(1);

      // asynchronous reset mid-stream
      out_ready = 1'b0;
      send(rand_instr(), $urandom, $urandom);
      send(rand_instr(), $urandom, $urandom);
      #2 rst_n = 1'b0;
      #1;
      chk("reset_valid", EW'(out_valid), '0);
      chk("reset_ready", EW'(in_ready), '0);
      chk("reset_outputs", {inputULA, srca, srcb, illegal}, '0);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(32'h00221820, 32'd100, 32'd23);
      send(32'h8C22FFFF, 32'd4, $urandom);

      // drain
      in_valid = 1'b0;
      flush    = 1'b0;
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
         @(posedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
